// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial-to-parallel receiver.
// - Bit-order codes for the dir input.
// - Receiver FSM state type.
// - Mode encodings of the upstream Universal_shift_reg, so stimulus can speak
//   the same language as the source block.
package shift_reg_pkg;

  localparam logic DIR_LSB_FIRST = 1'b0;  // source shifts right, drives LSBout
  localparam logic DIR_MSB_FIRST = 1'b1;  // source shifts left, drives MSBout

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } deser_state_e;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } usr_mode_e;

endpackage

// File: rtl/deser_out_buffer.sv
// One-word valid/ready holding register with sticky overrun.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push_valid      a completed word is offered this cycle
//   push_data       the offered word
//   pop_ready       consumer accepts data this cycle
//   clr_ovr         synchronous clear of the overrun flag
//   data, valid     held word and its valid flag
//   overrun         sticky: an offered word was dropped
module deser_out_buffer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             drop;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    drop    = 1'b0;
    if (push_valid) begin
      // A slot is free if empty, or if the current word leaves on this edge.
      if (!valid_q || pop_ready) begin
        data_d  = push_data;
        valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (valid_q && pop_ready) begin
      valid_d = 1'b0;
    end
    // A new drop beats a simultaneous clear request.
    overrun_d = (overrun_q & ~clr_ovr) | drop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/shift_reg_deserializer.sv
// Serial-in, parallel-out receiver for the Universal_shift_reg serial outputs.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   sin, sin_valid  serial bit and its strobe
//   dir             bit order (0 LSB first, 1 MSB first), latched at frame start
//   clr             abort the partial frame
//   clr_ovr         clear the overrun flag
//   dout_ready      consumer accepts dout
//   dout, dout_valid completed word and valid flag
//   busy            frame in progress
//   overrun         sticky: a completed word was dropped
module shift_reg_deserializer
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             dir,
  input  logic             clr,
  input  logic             clr_ovr,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  deser_state_e     state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             busy_q;
  logic             done_q, done_d;
  logic             dir_sel;
  logic [WIDTH-1:0] shifted;

  // The first bit of a frame uses the live dir; later bits use the latched one.
  assign dir_sel = (state_q == IDLE) ? dir : dir_q;

  generate
    if (WIDTH == 1) begin : g_w1
      assign shifted = sin;
    end else begin : g_wn
      assign shifted = (dir_sel == DIR_MSB_FIRST) ? {sreg_q[WIDTH-2:0], sin}
                                                  : {sin, sreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (clr) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (sin_valid) begin
      sreg_d = shifted;
      case (state_q)
        IDLE: begin
          dir_d = dir;
          if (WIDTH == 1) begin
            done_d = 1'b1;
          end else begin
            cnt_d   = CW'(1);
            state_d = RECV;
          end
        end
        RECV: begin
          if (cnt_q == CW'(WIDTH - 1)) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= (state_d == RECV);
      done_q  <= done_d;
    end
  end

  // done_q marks the cycle after the final shift, when sreg_q holds the word.
  deser_out_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push_valid(done_q),
    .push_data (sreg_q),
    .pop_ready (dout_ready),
    .clr_ovr   (clr_ovr),
    .data      (dout),
    .valid     (dout_valid),
    .overrun   (overrun)
  );

  assign busy = busy_q;

endmodule

// File: doc/shift_reg_deserializer.md
Name: shift_reg_deserializer

Overview:
Serial-in, parallel-out receiver for the far end of the Universal_shift_reg serial outputs.
- Takes the bit stream from MSBout or LSBout, one bit per strobe, and reassembles WIDTH-bit words.
- Hands each completed word to a consumer through a one-word valid/ready holding register.
- Flags overrun when a completed word cannot be stored.

Parameters:
WIDTH, 4, word width in bits; legal range ≥1.
CW, $clog2(WIDTH+1) (localparam, derived), bit counter width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
sin  input  1  serial data bit.
sin_valid  input  1  sin is sampled on this clk edge.
dir  input  1  bit order: 0 = LSB first (source shifting right, LSBout); 1 = MSB first (source shifting left, MSBout). Sampled at frame start.
clr  input  1  sync abort: discards the partial word and returns to IDLE; holding register untouched.
clr_ovr  input  1  sync clear of the overrun flag.
dout_ready  input  1  consumer accepts dout this cycle.
dout  output  WIDTH  completed word.
dout_valid  output  1  dout holds an unconsumed word.
busy  output  1  frame in progress (state RECV).
overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (rst=0, async): state=IDLE, shift reg=0, cnt=0, dir_lat=0, dout=0, dout_valid=0, busy=0, overrun=0. Reset mid-frame discards everything.
- FSM states: IDLE, RECV.
  - IDLE + sin_valid: latch dir_lat=dir, capture bit, cnt=1, go to RECV. If WIDTH=1, the word completes instead and the FSM stays in IDLE.
  - RECV + sin_valid: capture bit, cnt+1. When the captured bit is the WIDTH-th, the word completes, cnt=0, go to IDLE.
  - RECV without sin_valid: hold. No timeout.
  - clr overrides sin_valid in both states: go to IDLE, cnt=0, the bit on that edge is ignored.
- Capture:
  - dir_lat=0: sreg <= {sin, sreg[WIDTH-1:1]}. The first bit lands in bit 0 at completion.
  - dir_lat=1: sreg <= {sreg[WIDTH-2:0], sin}. The first bit lands in bit WIDTH-1.
  - dir changes mid-frame are ignored.
- Completion word = value after the final shift. Presented on dout with dout_valid=1 the following edge, giving 1-cycle latency from the final sin_valid edge.
- Handshake:
  - A word is consumed on an edge with dout_valid & dout_ready; dout_valid then drops unless a new word loads on the same edge.
  - dout stays stable while dout_valid=1 and not consumed.
  - dout_ready with dout_valid=0 has no effect.
- Boundaries:
  - Completion with holding empty: load.
  - Completion with holding full and dout_ready=1 on the same edge: old word consumed, new word loaded, dout_valid stays 1.
  - Completion with holding full and dout_ready=0: new word dropped, overrun<=1, holding word preserved.
  - clr_ovr and a new overrun on the same edge: overrun=1 (set wins).
  - clr on the completing edge: the abort wins and no word loads.
- busy = (state==RECV), registered.

Decomposition:
- Package shift_reg_pkg holds:
  - DIR_LSB_FIRST=1'b0 and DIR_MSB_FIRST=1'b1.
  - State enum {IDLE, RECV}.
  - Universal_shift_reg mode encodings {HOLD=2'b00, SHR=2'b01, SHL=2'b10, LOAD=2'b11}, shared with bench stimulus.
- One sub-module: deser_out_buffer, the one-word valid/ready holding register with overrun detection.
- Shift register, counter and FSM stay in the top.

Test Plan:
1. LSB-first word:
   - Stimulus: WIDTH=4, dir=0, sin_valid each cycle, bits 1,0,1,1.
   - Response: dout=4'b1101, dout_valid=1 one cycle after the 4th bit; busy high for cycles 1–3 only.
2. MSB-first word:
   - Stimulus: dir=1, bits 1,0,0,1 with a 3-cycle sin_valid gap after bit 2.
   - Response: dout=4'b1001; the gap does not corrupt the word.
3. Back-to-back with ready:
   - Stimulus: two words 4'hA then 4'h5 sent continuously, dout_ready=1 on the completion edge of word 2.
   - Response: dout_valid stays 1 throughout, dout changes A->5, overrun=0.
4. Overrun:
   - Stimulus: dout_ready held 0, send 4'h3 then 4'hC.
   - Response: dout stays 4'h3, overrun=1 after the 2nd completion. Pulsing clr_ovr clears overrun; dout_ready=1 then drops dout_valid.
5. Abort and dir latch:
   - Stimulus: send 2 bits, assert clr, flip dir mid-way in the next frame, send 4'b0110 LSB-first.
   - Response: the partial bits are discarded, dout=4'b0110, and the dir flip has no effect.
6. Async reset mid-frame:
   - Stimulus: drop rst between clock edges after 3 bits, release, send a full word.
   - Response: all outputs 0 immediately on rst=0, and the next word decodes correctly starting from cnt=0.
